// File: rtl/boot_hex_pkg.sv
// Shared types and character constants for the boot hex loader.
package boot_hex_pkg;

    // Parser states; StSlash/StComment are only entered when comments are enabled.
    typedef enum logic [2:0] {
        StIdle,
        StData,
        StAddr,
        StError,
        StSlash,
        StComment
    } state_e;

    // First-error cause reported on error_code.
    typedef enum logic [1:0] {
        ErrBadChar  = 2'd0,
        ErrDataLong = 2'd1,
        ErrAddrLong = 2'd2,
        ErrEmptyAt  = 2'd3
    } err_code_e;

    localparam int unsigned nibble_width = 4;

    // ASCII codes, widened so any char_width up to 32 compares without truncation.
    localparam logic [31:0] char_zero  = 32'h30;
    localparam logic [31:0] char_nine  = 32'h39;
    localparam logic [31:0] char_a_lo  = 32'h61;
    localparam logic [31:0] char_f_lo  = 32'h66;
    localparam logic [31:0] char_a_up  = 32'h41;
    localparam logic [31:0] char_f_up  = 32'h46;
    localparam logic [31:0] char_at    = 32'h40;
    localparam logic [31:0] char_slash = 32'h2f;
    localparam logic [31:0] char_space = 32'h20;
    localparam logic [31:0] char_tab   = 32'h09;
    localparam logic [31:0] char_cr    = 32'h0d;
    localparam logic [31:0] char_lf    = 32'h0a;

endpackage

// File: rtl/boot_hex_char_class.sv
// Combinational character classifier: hex digit (with nibble value), separator, '@', '/'.
module boot_hex_char_class
    import boot_hex_pkg::*;
#(
    parameter int unsigned char_width = 8
) (
    input  logic [char_width-1:0]   in_char,
    output logic                    is_hex,
    output logic                    is_sep,
    output logic                    is_at,
    output logic                    is_slash,
    output logic [nibble_width-1:0] nibble
);

    logic [31:0] c;
    logic        is_digit;
    logic        is_lower;
    logic        is_upper;

    // Classify and decode; for letters the low nibble of ASCII plus 9 gives 10..15.
    always_comb begin
        c        = 32'(in_char);
        is_digit = (c >= char_zero) && (c <= char_nine);
        is_lower = (c >= char_a_lo) && (c <= char_f_lo);
        is_upper = (c >= char_a_up) && (c <= char_f_up);
        is_hex   = is_digit || is_lower || is_upper;
        is_sep   = (c == char_space) || (c == char_tab) || (c == char_cr) || (c == char_lf);
        is_at    = (c == char_at);
        is_slash = (c == char_slash);
        nibble   = is_digit ? c[3:0] : c[3:0] + 4'd9;
    end

endmodule

// File: rtl/boot_hex_loader.sv
// Boot-time memory-image-style stream parser: hex words and "@addr" directives become
// (address, data) write strobes. An inactivity timeout ends the session and clears errors.
// Optional: define BOOT_HEX_COMMENT_EN to accept "//" line comments.
module boot_hex_loader
    import boot_hex_pkg::*;
#(
    parameter int unsigned address_width      = 32,
    parameter int unsigned data_width         = 32,
    parameter int unsigned char_width         = 8,
    parameter int unsigned clk_frequency      = 50000000,
    parameter int unsigned timeout_in_seconds = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [char_width-1:0]    in_char,
    output logic                     out_valid,
    output logic [address_width-1:0] out_address,
    output logic [data_width-1:0]    out_data,
    output logic                     busy,
    output logic                     error,
    output logic [1:0]               error_code
);

    localparam int unsigned data_nibbles   = data_width / nibble_width;
    localparam int unsigned addr_nibbles   = address_width / nibble_width;
    localparam int unsigned acc_width      = (data_width > address_width) ? data_width
                                                                          : address_width;
    localparam int unsigned count_width    = $clog2((acc_width / nibble_width) + 1);
    localparam int unsigned timeout_cycles = clk_frequency * timeout_in_seconds;
    localparam int unsigned counter_width  = (timeout_cycles > 1) ? $clog2(timeout_cycles + 1)
                                                                  : 1;
`ifdef BOOT_HEX_COMMENT_EN
    localparam bit comment_en = 1'b1;
`else
    localparam bit comment_en = 1'b0;
`endif

    logic                     is_hex, is_sep, is_at, is_slash;
    logic [nibble_width-1:0]  nibble;

    state_e                   state_q, state_d, sess_state;
    logic [acc_width-1:0]     acc_q, acc_d, sess_acc;
    logic [count_width-1:0]   count_q, count_d, sess_count;
    logic [address_width-1:0] next_addr_q, next_addr_d, sess_addr;
    logic                     error_q, error_d, sess_error;
    err_code_e                error_code_q, error_code_d, sess_code;
    logic                     out_valid_q, out_valid_d;
    logic [data_width-1:0]    out_data_q, out_data_d;
    logic [address_width-1:0] out_address_q, out_address_d;
    logic [counter_width-1:0] counter_q, counter_d;

    logic                     raise, emit, set_addr;
    err_code_e                raise_code;

    boot_hex_char_class #(
        .char_width (char_width)
    ) u_char_class (
        .in_char  (in_char),
        .is_hex   (is_hex),
        .is_sep   (is_sep),
        .is_at    (is_at),
        .is_slash (is_slash),
        .nibble   (nibble)
    );

`ifdef BOOT_HEX_COMMENT_EN
    logic is_lf;
    assign is_lf = (32'(in_char) == char_lf);
`endif

    // Effective session context: an expired counter means a fresh session starting now.
    always_comb begin
        sess_state = state_q;
        sess_acc   = acc_q;
        sess_count = count_q;
        sess_addr  = next_addr_q;
        sess_error = error_q;
        sess_code  = error_code_q;
        if (counter_q == '0) begin
            sess_state = StIdle;
            sess_acc   = '0;
            sess_count = '0;
            sess_addr  = '0;
            sess_error = 1'b0;
            sess_code  = ErrBadChar;
        end
    end

    // Next-state, token accumulation, error capture and write emission.
    always_comb begin
        state_d       = sess_state;
        acc_d         = sess_acc;
        count_d       = sess_count;
        next_addr_d   = sess_addr;
        error_d       = sess_error;
        error_code_d  = sess_code;
        out_valid_d   = 1'b0;
        out_data_d    = out_data_q;
        out_address_d = out_address_q;
        counter_d     = (counter_q == '0) ? '0 : counter_q - 1'b1;
        raise         = 1'b0;
        raise_code    = ErrBadChar;
        emit          = 1'b0;
        set_addr      = 1'b0;

        if (in_valid) begin
            counter_d = counter_width'(timeout_cycles);
            unique case (sess_state)
                StIdle: begin
                    if (is_hex) begin
                        acc_d   = acc_width'(nibble);
                        count_d = count_width'(1);
                        state_d = StData;
                    end else if (is_at) begin
                        acc_d   = '0;
                        count_d = '0;
                        state_d = StAddr;
                    end else if (is_slash && comment_en) begin
                        state_d = StSlash;
                    end else if (!is_sep) begin
                        raise = 1'b1;
                    end
                end
                StData: begin
                    if (is_hex) begin
                        if (sess_count < count_width'(data_nibbles)) begin
                            acc_d   = {sess_acc[acc_width-nibble_width-1:0], nibble};
                            count_d = sess_count + 1'b1;
                        end else begin
                            raise      = 1'b1;
                            raise_code = ErrDataLong;
                        end
                    end else if (is_sep) begin
                        emit    = 1'b1;
                        state_d = StIdle;
                    end else if (is_slash && comment_en) begin
                        emit    = 1'b1;
                        state_d = StSlash;
                    end else begin
                        raise = 1'b1;
                    end
                end
                StAddr: begin
                    if (is_hex) begin
                        if (sess_count < count_width'(addr_nibbles)) begin
                            acc_d   = {sess_acc[acc_width-nibble_width-1:0], nibble};
                            count_d = sess_count + 1'b1;
                        end else begin
                            raise      = 1'b1;
                            raise_code = ErrAddrLong;
                        end
                    end else if (is_sep || (is_slash && comment_en)) begin
                        if (sess_count == '0) begin
                            raise      = 1'b1;
                            raise_code = ErrEmptyAt;
                        end else begin
                            set_addr = 1'b1;
                            if (is_sep) begin
                                state_d = StIdle;
                            end else begin
                                state_d = StSlash;
                            end
                        end
                    end else begin
                        raise = 1'b1;
                    end
                end
                StError: begin
                    // Sticky until timeout or reset.
                end
`ifdef BOOT_HEX_COMMENT_EN
                StSlash: begin
                    if (is_slash) begin
                        state_d = StComment;
                    end else begin
                        raise = 1'b1;
                    end
                end
                StComment: begin
                    if (is_lf) begin
                        state_d = StIdle;
                    end
                end
`endif
                default: begin
                    state_d = StIdle;
                end
            endcase

            if (raise) begin
                state_d      = StError;
                error_d      = 1'b1;
                error_code_d = raise_code;
            end
            if (set_addr) begin
                next_addr_d = sess_acc[address_width-1:0];
            end
            if (emit) begin
                out_valid_d   = 1'b1;
                out_data_d    = sess_acc[data_width-1:0];
                out_address_d = sess_addr;
                next_addr_d   = sess_addr + address_width'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            acc_q         <= '0;
            count_q       <= '0;
            next_addr_q   <= '0;
            error_q       <= 1'b0;
            error_code_q  <= ErrBadChar;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_address_q <= '0;
            counter_q     <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            count_q       <= count_d;
            next_addr_q   <= next_addr_d;
            error_q       <= error_d;
            error_code_q  <= error_code_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_address_q <= out_address_d;
            counter_q     <= counter_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_address = out_address_q;
    assign busy        = (counter_q != '0);
    assign error       = error_q;
    assign error_code  = error_code_q;

endmodule

// File: doc/boot_hex_loader.md
Name: boot_hex_loader

Overview:
- Parametrised successor to the boot-time ASCII hex word parser, used in the UART boot path in front of the memory write port.
- Parses a $readmemh-style stream: whitespace-separated hex words of configurable width, plus "@<hex>" address directives.
- Emits one (address, data) write per completed word and reports structured error codes.
- Uses an inactivity timeout to end a boot session and clear error state.

Parameters:
- address_width, 32, width of the word address output.
- data_width, 32, word width; must be a multiple of 4.
- char_width, 8, input character width.
- clk_frequency, 50000000, clock frequency in Hz.
- timeout_in_seconds, 1, inactivity time that ends a session.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_char is valid this cycle (single-cycle strobe)
- in_char  in  char_width  ASCII character
- out_valid  out  1  one-cycle write strobe
- out_address  out  address_width  word address of out_data
- out_data  out  data_width  parsed word
- busy  out  1  session active (timeout counter non-zero)
- error  out  1  sticky error flag
- error_code  out  2  first error cause: 0 bad character, 1 data token too long, 2 address token too long, 3 empty "@"

Behaviour:
- Reset values: all outputs 0; state IDLE; nibble count 0; timeout counter 0.
- Timeout counter:
  - Loads clk_frequency*timeout_in_seconds on every in_valid; otherwise decrements to 0.
  - busy = (counter != 0).
  - On the cycle the counter is 0: state goes to IDLE, the partial token is discarded, next address is cleared to 0, and error and error_code are cleared.
- Character classes:
  - hex: 0-9, a-f, A-F.
  - separator: space, TAB, CR, LF.
  - at: "@".
  - Anything else is bad.
- States: IDLE, DATA, ADDR, ERROR. Characters are consumed only when in_valid is 1.
- IDLE:
  - hex: load the nibble into the accumulator, count=1, go to DATA.
  - at: clear the accumulator, count=0, go to ADDR.
  - separator: stay in IDLE.
  - bad: go to ERROR, code 0.
- DATA:
  - hex with count < data_width/4: accumulator = (acc<<4)|nibble, count+1.
  - hex with count == data_width/4: go to ERROR, code 1.
  - separator: emit the word, go to IDLE.
  - at or bad: go to ERROR, code 0.
- ADDR:
  - hex with count < address_width/4: shift in, count+1.
  - hex otherwise: go to ERROR, code 2.
  - separator with count == 0: go to ERROR, code 3.
  - separator with count > 0: next address = accumulator, go to IDLE. No word is emitted.
  - at or bad: go to ERROR, code 0.
- ERROR:
  - Characters are ignored and no writes are made until timeout or reset.
  - error=1; error_code holds the first cause.
- Emit:
  - The cycle after the terminating separator: out_valid=1, out_data = accumulator zero-extended (short tokens are right-aligned), out_address = next address.
  - Next address then increments by 1 and wraps modulo 2^address_width.
  - out_data and out_address hold their values until the next emit.
- Latency: 1 clk from the separator strobe to out_valid. There is no backpressure; the consumer must accept every strobe.
- Back-to-back in_valid on consecutive cycles must be supported.
- An incomplete token at timeout is dropped without an error.

Optional Feature:
- Macro BOOT_HEX_COMMENT_EN.
- Defined:
  - Adds states SLASH and COMMENT.
  - "/" in IDLE goes to SLASH. A second "/" goes to COMMENT; any other character in SLASH goes to ERROR, code 0.
  - COMMENT ignores all characters until LF, then goes to IDLE.
  - "/" in DATA terminates and emits the word, then enters SLASH. "/" in ADDR is handled like a separator, then enters SLASH.
- Undefined: "/" is a bad character (code 0).

Decomposition:
- Package boot_hex_pkg:
  - state enum.
  - error-code enum.
  - character localparams (0, 9, a, f, A, F, @, /, SP, TAB, CR, LF).
  - nibble_width = 4.
- Sub-module boot_hex_char_class: combinational; in_char to {is_hex, is_sep, is_at, is_slash, nibble}.

Test Plan:
- "0000ABCD\n12345678\n" with reset defaults -> writes (0,0000ABCD), (1,12345678); error=0.
- "@10 FF 7\n" -> writes (16,000000FF), (17,00000007).
- "123456789 " -> error=1, code 1, no write; after 1 s idle (shortened clk_frequency in the bench), error=0 and "1 " writes (0,00000001).
- "@ 5" -> code 3; separately "@123456789" -> code 2; separately "AG" -> code 0; no writes in any case.
- "@FFFFFFFF 1 2 " -> writes at FFFFFFFF then 00000000 (wrap).
- With BOOT_HEX_COMMENT_EN defined, "// x@G\nAB\n" -> single write (0,000000AB). With it undefined, the same stream gives error code 0.
